// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle for branch_resolve_unit: EX-side request, fetch-side result
// and the optional performance counters. The master drives requests; the unit is the slave.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        cmp_op;
  logic              pred_taken;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   target;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              taken;
  logic              mispredict;
  logic [PC_W-1:0]   redirect_pc;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output in_valid, a, b, cmp_op, pred_taken, pc, target, flush, out_ready,
    input  in_ready, out_valid, taken, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    input  in_valid, a, b, cmp_op, pred_taken, pc, target, flush, out_ready,
    output in_ready, out_valid, taken, mispredict, redirect_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch condition evaluation with a 2-entry result FIFO and valid/ready on both sides.
// Define BRU_PERF_CNT_EN to build the saturating branch / mispredict counters.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} q_state_t;

  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
  } result_t;

  q_state_t state, state_n;
  result_t  head, tail, res_new;
  logic     in_ready_q, out_valid_q;
  logic     cond, sign, a_zero;
  logic     accept, pop;

  assign sign   = bus.a[DATA_W-1];
  assign a_zero = (bus.a == '0);

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cond = 1'b0;
    unique case (bus.cmp_op)
      3'b000: cond = (bus.a == bus.b);
      3'b001: cond = (bus.a != bus.b);
      3'b010: cond = ~sign & ~a_zero;
      3'b011: cond = sign | a_zero;
      3'b100: cond = sign;
      3'b101: cond = ~sign;
      3'b110: cond = 1'b1;
      3'b111: cond = 1'b0;
      default: cond = 1'b0;
    endcase
    res_new.taken       = cond;
    res_new.mispredict  = cond ^ bus.pred_taken;
    res_new.redirect_pc = cond ? bus.target : bus.pc + PC_W'(4);
  end

  assign accept = bus.in_valid & in_ready_q & ~bus.flush;
  assign pop    = out_valid_q & bus.out_ready & ~bus.flush;

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY:   if (accept) state_n = ONE;
      ONE: begin
        if (accept && !pop)      state_n = FULL;
        else if (pop && !accept) state_n = EMPTY;
      end
      FULL:    if (pop) state_n = ONE;
      default: state_n = EMPTY;
    endcase
    if (bus.flush) state_n = EMPTY;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head        <= '0;
    end else begin
      state       <= state_n;
      in_ready_q  <= (state_n != FULL);
      out_valid_q <= (state_n != EMPTY);
      if (!bus.flush) begin
        unique case (state)
          EMPTY:   if (accept) head <= res_new;
          ONE:     if (accept && pop) head <= res_new;
          FULL:    if (pop) head <= tail;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the second slot is plain storage with no reset; it is only ever read
  // after being written, so resetting it would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (accept && state == ONE && !pop) tail <= res_new;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.taken       = head.taken;
  assign bus.mispredict  = head.mispredict;
  assign bus.redirect_pc = head.redirect_pc;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  // Counters saturate at all-ones; flush never clears them, only rst does.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (accept) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (res_new.mispredict && mispred_cnt_q != '1)
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
`else
  assign bus.branch_cnt  = '0;
  assign bus.mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed steps followed by random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;

  typedef struct {
    bit          taken;
    bit          mis;
    bit [31:0]   rpc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_resolve_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  bit   exp_rdy = 1'b0;
  int   br_total = 0;
  int   mis_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input bit [2:0] op, input bit [31:0] av, input bit [31:0] bv);
    case (op)
      3'd0: return av == bv;
      3'd1: return av != bv;
      3'd2: return $signed(av) > 0;
      3'd3: return $signed(av) <= 0;
      3'd4: return $signed(av) < 0;
      3'd5: return $signed(av) >= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef BRU_PERF_CNT_EN
    return (n > 15) ? 4'd15 : n[CNT_W-1:0];
`else
    return '0;
`endif
  endfunction

  task automatic drive(input bit v, input bit [2:0] op, input bit [31:0] av, input bit [31:0] bv,
                       input bit pt, input bit [31:0] pcv, input bit [31:0] tgv,
                       input bit fl, input bit ordy);
    bus.in_valid   = v;
    bus.cmp_op     = op;
    bus.a          = av;
    bus.b          = bv;
    bus.pred_taken = pt;
    bus.pc         = pcv;
    bus.target     = tgv;
    bus.flush      = fl;
    bus.out_ready  = ordy;
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare 1 time unit after the edge.
  task automatic step(input string tag);
    bit   acc, pp;
    res_t r;
    if (rst) begin
      exp_q.delete();
      exp_rdy   = 1'b0;
      br_total  = 0;
      mis_total = 0;
    end else begin
      acc     = bus.in_valid && exp_rdy && !bus.flush;
      pp      = (exp_q.size() > 0) && bus.out_ready && !bus.flush;
      r.taken = ref_taken(bus.cmp_op, bus.a, bus.b);
      r.mis   = r.taken != bus.pred_taken;
      r.rpc   = r.taken ? bus.target : bus.pc + 32'd4;
      if (bus.flush) exp_q.delete();
      else begin
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back(r);
          br_total++;
          if (r.mis) mis_total++;
        end
      end
      exp_rdy = exp_q.size() < 2;
    end
    @(posedge clk);
    #1;
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check({tag, ".taken"}, 64'(bus.taken), 64'(exp_q[0].taken));
      check({tag, ".mispredict"}, 64'(bus.mispredict), 64'(exp_q[0].mis));
      check({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(exp_q[0].rpc));
    end else if (rst) begin
      check({tag, ".rst_taken"}, 64'(bus.taken), 64'd0);
      check({tag, ".rst_mispredict"}, 64'(bus.mispredict), 64'd0);
      check({tag, ".rst_redirect_pc"}, 64'(bus.redirect_pc), 64'd0);
    end
    check({tag, ".branch_cnt"}, 64'(bus.branch_cnt), 64'(exp_cnt(br_total)));
    check({tag, ".mispred_cnt"}, 64'(bus.mispred_cnt), 64'(exp_cnt(mis_total)));
  endtask

  initial begin
    bit [31:0]        sweep_a [3];
    logic [CNT_W-1:0] cnt_before;
    sweep_a[0] = 32'h0000_0000;
    sweep_a[1] = 32'h0000_0001;
    sweep_a[2] = 32'h8000_0000;

    // Reset
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("post_reset");

    // BEQ taken, predicted not taken
    drive(1, 3'd0, 32'h1234, 32'h1234, 0, 32'h100, 32'h200, 0, 0);
    step("beq");
    check("beq_taken_const", 64'(bus.taken), 64'd1);
    check("beq_mispredict_const", 64'(bus.mispredict), 64'd1);
    check("beq_redirect_const", 64'(bus.redirect_pc), 64'h200);
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    step("beq_drain");

    // Sign / zero sweep of ops 010..101, plus ALWAYS / NEVER, streaming with out_ready=1
    for (int op = 2; op <= 5; op++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1, 3'(op), sweep_a[k], 32'h5555, 0, 32'h1000 + 32'(op * 16 + k * 4), 32'h8000, 0, 1);
        step("sweep");
      end
    end
    drive(1, 3'd6, 0, 0, 0, 32'h40, 32'h80, 0, 1);
    step("always");
    check("always_taken_const", 64'(bus.taken), 64'd1);
    drive(1, 3'd7, 0, 0, 1, 32'h40, 32'h80, 0, 1);
    step("never");
    check("never_taken_const", 64'(bus.taken), 64'd0);
    check("never_redirect_const", 64'(bus.redirect_pc), 64'h44);
    drive(1, 3'd3, 32'h8000_0000, 0, 0, 32'h10, 32'h20, 0, 1);
    step("blez_neg");
    check("blez_neg_taken_const", 64'(bus.taken), 64'd1);
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    step("sweep_drain");

    // Backpressure: three back-to-back requests with out_ready=0
    drive(1, 3'd1, 1, 2, 1, 32'h300, 32'h900, 0, 0);
    step("bp1");
    drive(1, 3'd0, 5, 6, 1, 32'h304, 32'h904, 0, 0);
    step("bp2");
    check("bp_full_in_ready_const", 64'(bus.in_ready), 64'd0);
    drive(1, 3'd6, 0, 0, 1, 32'h308, 32'h908, 0, 0);
    step("bp3_blocked");
    drive(1, 3'd6, 0, 0, 1, 32'h308, 32'h908, 0, 1);
    step("bp3_release");
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    step("bp_drain1");
    step("bp_drain2");
    step("bp_drain3");

    // BNE not taken at top of PC space wraps to zero
    drive(1, 3'd1, 32'h77, 32'h77, 0, 32'hFFFF_FFFC, 32'h1234, 0, 0);
    step("bne_wrap");
    check("bne_wrap_const", 64'(bus.redirect_pc), 64'h0);
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    step("wrap_drain");

    // Fill queue, then flush with a concurrent request
    drive(1, 3'd6, 0, 0, 0, 32'h500, 32'h600, 0, 0);
    step("fill1");
    step("fill2");
    cnt_before = bus.branch_cnt;
    drive(1, 3'd6, 0, 0, 0, 32'h504, 32'h604, 1, 1);
    step("flush");
    check("flush_out_valid_const", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready_const", 64'(bus.in_ready), 64'd1);
    check("flush_cnt_unchanged", 64'(bus.branch_cnt), 64'(cnt_before));

    // 20 mispredicted branches saturate 4-bit counters when enabled
    rst = 1'b1;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    step("mid_reset");
    rst = 1'b0;
    step("mid_reset_release");
    for (int i = 0; i < 20; i++) begin
      drive(1, 3'd6, 0, 0, 0, 32'(i * 4), 32'hA000, 0, 1);
      step("sat");
    end
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    step("sat_drain");
`ifdef BRU_PERF_CNT_EN
    check("sat_branch_cnt_const", 64'(bus.branch_cnt), 64'd15);
    check("sat_mispred_cnt_const", 64'(bus.mispred_cnt), 64'd15);
`else
    check("off_branch_cnt_const", 64'(bus.branch_cnt), 64'd0);
    check("off_mispred_cnt_const", 64'(bus.mispred_cnt), 64'd0);
`endif
    rst = 1'b1;
    step("cnt_reset");
    check("cnt_reset_branch_const", 64'(bus.branch_cnt), 64'd0);
    check("cnt_reset_mispred_const", 64'(bus.mispred_cnt), 64'd0);
    rst = 1'b0;
    step("cnt_reset_release");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit [31:0] av, bv;
      case ($urandom_range(0, 4))
        0: av = 32'h0;
        1: av = 32'h1;
        2: av = 32'h8000_0000;
        3: av = 32'hFFFF_FFFF;
        default: av = $urandom;
      endcase
      bv = ($urandom_range(0, 2) == 0) ? av : $urandom;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), av, bv, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the combinational branch comparator: evaluates the branch condition for `DATA_W`-bit operands, checks it against the front end's prediction, and produces taken/mispredict flags plus the redirect PC. Sits between the EX-stage operand bypass and the fetch redirect / flush logic. Results are buffered in a 2-entry output queue with valid/ready handshakes on both sides. Optional saturating performance counters track branch and mispredict totals.

## Interface
Parameters:
- `DATA_W`, 32, operand width; sign bit is `a[DATA_W-1]`
- `PC_W`, 32, PC / target width
- `CNT_W`, 16, perf counter width (used only with `BRU_PERF_CNT_EN`)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  branch request present
- `in_ready`  out  1  unit can accept; registered, equals "queue not full"
- `a`  in  DATA_W  first operand (rs)
- `b`  in  DATA_W  second operand (rt)
- `cmp_op`  in  3  condition code, see Operation
- `pred_taken`  in  1  front-end prediction
- `pc`  in  PC_W  branch instruction PC
- `target`  in  PC_W  taken target
- `flush`  in  1  kill all queued results and the same-cycle request
- `out_valid`  out  1  result at queue head
- `out_ready`  in  1  consumer takes head
- `taken`  out  1  resolved direction
- `mispredict`  out  1  `taken != pred_taken`
- `redirect_pc`  out  PC_W  correct next PC
- `branch_cnt`  out  CNT_W  accepted branches
- `mispred_cnt`  out  CNT_W  accepted mispredicts

## Operation
- `cmp_op` encoding: 000 BEQ (a==b), 001 BNE (a!=b), 010 BGTZ (sign 0 and a!=0), 011 BLEZ (sign 1 or a==0), 100 BLTZ (sign 1), 101 BGEZ (sign 0), 110 ALWAYS (taken=1), 111 NEVER (taken=0).
- `redirect_pc` = `taken ? target : pc + 4`, computed in PC_W bits, wraps modulo 2^PC_W.
- Accept = `in_valid & in_ready & ~flush`. At accept the evaluated {taken, mispredict, redirect_pc} is written to the queue tail.
- Pop = `out_valid & out_ready & ~flush`.
- Queue states: EMPTY (0 entries), ONE, FULL (2 entries).
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> FULL; pop & ~accept -> EMPTY; accept & pop -> ONE (new entry becomes head).
  - FULL: pop -> ONE; no accept possible (`in_ready`=0).
  - Any state: flush -> EMPTY next cycle, regardless of `in_valid`/`out_ready`.
- Head ordering is strict FIFO; results are never reordered.
- Output fields hold stable while `out_valid`=1 and `out_ready`=0.
- Outputs `taken`, `mispredict`, `redirect_pc` are don't-care when `out_valid`=0, but are driven from registers (no combinational path from inputs).

## Timing
- Reset values: `out_valid`=0, `in_ready`=0 during the reset cycle and 1 from the first cycle after, `taken`=0, `mispredict`=0, `redirect_pc`=0, `branch_cnt`=0, `mispred_cnt`=0; queue EMPTY.
- Latency: accepted at edge N -> `out_valid`=1 with that result after edge N (cycle N+1), when the queue was EMPTY.
- Throughput: 1 branch/cycle sustained while `out_ready`=1.
- `in_ready` depends only on registered state; it never depends combinationally on `out_ready`.
- Flush cycle: `in_ready` may be 1, but the request is dropped and not counted.
- Reset asserted mid-operation: queue and counters clear at the next edge, same as power-up.

## Configuration
- `BRU_PERF_CNT_EN` defined: `branch_cnt` increments on every accept; `mispred_cnt` increments on every accept whose result has `mispredict`=1. Both saturate at all-ones and do not wrap. Flush does not clear them; only `rst` does.
- Not defined: counter registers are not built, and `branch_cnt`/`mispred_cnt` are tied to 0.

## Test plan
- BEQ a=b=0x1234, pred_taken=0, pc=0x100, target=0x200 -> next cycle out_valid=1, taken=1, mispredict=1, redirect_pc=0x200.
- Sweep ops 010–101 with a=0, a=1, a=0x80000000 plus ops 110/111 -> taken matches the encoding table; e.g. BLEZ taken for 0 and 0x80000000, not for 1.
- out_ready=0, three back-to-back requests -> the first two are accepted, in_ready=0 on the third; release out_ready -> results emerge in order and the third is accepted.
- BNE not taken with pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- Queue FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, request dropped, branch_cnt unchanged.
- With BRU_PERF_CNT_EN and CNT_W=4: 20 mispredicted branches -> branch_cnt=mispred_cnt=15 (saturated); rst -> both 0.
